// File: rtl/save_exec_fsm_pkg.sv
// Shared state encoding for the save/execute record-playback controller.
package save_exec_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/save_exec_fsm_rise_detect.sv
// Rising-edge detector: one-cycle-wide 'rise' when 'd' goes from 0 to 1.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic r_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_d_q <= 1'b0;
    else       r_d_q <= d;
  end

  assign rise = d & ~r_d_q;

endmodule

// File: rtl/save_exec_fsm.sv
// FIFO record/playback sequencer with Moore strobes for write, read and timer run.
// Build option: SAVE_EXEC_FSM_ABORT_EN lets a save press abort playback from READ/WAIT.
module save_exec_fsm
  import save_exec_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic save,
  input  logic execute,
  input  logic empty,
  input  logic full,
  input  logic timer,
  output logic write_enable,
  output logic read_enable,
  output logic timer_enable
);

  state_t r_state;
  state_t w_next;
  logic   w_save_rise;
  logic   w_exec_rise;

  rise_detect u_save_rise (
    .clk   (clk),
    .reset (reset),
    .d     (save),
    .rise  (w_save_rise)
  );

  rise_detect u_exec_rise (
    .clk   (clk),
    .reset (reset),
    .d     (execute),
    .rise  (w_exec_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        // save takes precedence; a simultaneous execute press is dropped
        if (w_save_rise) begin
          if (!full) w_next = WRITE;
        end else if (w_exec_rise && !empty) begin
          w_next = READ;
        end
      end
      WRITE: w_next = IDLE;
`ifdef SAVE_EXEC_FSM_ABORT_EN
      READ:  w_next = w_save_rise ? IDLE : WAIT;
      WAIT: begin
        if (w_save_rise)  w_next = IDLE;
        else if (timer)   w_next = empty ? IDLE : READ;
      end
`else
      READ:  w_next = WAIT;
      WAIT: begin
        if (timer) w_next = empty ? IDLE : READ;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  assign write_enable = (r_state == WRITE);
  assign read_enable  = (r_state == READ);
  assign timer_enable = (r_state == WAIT);

endmodule

// File: tb/tb_save_exec_fsm.sv
// Directed self-checking bench for save_exec_fsm; outputs checked as {write,read,timer}.
module tb_save_exec_fsm;

  logic clk = 1'b0;
  logic reset;
  logic save, execute, empty, full, timer;
  logic write_enable, read_enable, timer_enable;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned wr_count;

  always #5 clk = ~clk;

  save_exec_fsm u_dut (
    .clk          (clk),
    .reset        (reset),
    .save         (save),
    .execute      (execute),
    .empty        (empty),
    .full         (full),
    .timer        (timer),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .timer_enable (timer_enable)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {29'd0, write_enable, read_enable, timer_enable};
  endfunction

  initial begin
    reset = 1'b1; save = 1'b0; execute = 1'b0;
    empty = 1'b1; full = 1'b0; timer = 1'b0;
    step(); step();
    check_eq("reset_outs", outs(), 32'b000);
    reset = 1'b0;
    step();
    check_eq("idle_outs", outs(), 32'b000);

    // single save pulse
    save = 1'b1; step();
    check_eq("save_we", outs(), 32'b100);
    save = 1'b0; step();
    check_eq("save_we_drop", outs(), 32'b000);

    // held save produces one strobe
    wr_count = 0;
    save = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (write_enable) wr_count++;
    end
    save = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (write_enable) wr_count++;
    end
    check_eq("hold_save_count", wr_count, 32'd1);

    // save while full ignored
    full = 1'b1; save = 1'b1; step();
    check_eq("full_save_t1", outs(), 32'b000);
    step();
    check_eq("full_save_t2", outs(), 32'b000);
    save = 1'b0; full = 1'b0; step();

    // timer in IDLE ignored
    timer = 1'b1; step();
    check_eq("idle_timer", outs(), 32'b000);
    timer = 1'b0;

    // execute, last entry
    empty = 1'b0; execute = 1'b1; step();
    check_eq("exec_re", outs(), 32'b010);
    execute = 1'b0; step();
    check_eq("exec_wait1", outs(), 32'b001);
    step();
    check_eq("exec_wait2", outs(), 32'b001);
    timer = 1'b1; empty = 1'b1; step();
    check_eq("exec_done", outs(), 32'b000);
    timer = 1'b0; step();
    check_eq("exec_idle", outs(), 32'b000);

    // execute, two entries
    empty = 1'b0; execute = 1'b1; step();
    check_eq("exec2_re1", outs(), 32'b010);
    execute = 1'b0; step();
    check_eq("exec2_wait1", outs(), 32'b001);
    timer = 1'b1; step();
    check_eq("exec2_re2", outs(), 32'b010);
    timer = 1'b0; step();
    check_eq("exec2_wait2", outs(), 32'b001);

    // save press during WAIT
    save = 1'b1; step();
`ifdef SAVE_EXEC_FSM_ABORT_EN
    check_eq("wait_save", outs(), 32'b000);
`else
    check_eq("wait_save", outs(), 32'b001);
`endif
    save = 1'b0; step();
`ifdef SAVE_EXEC_FSM_ABORT_EN
    check_eq("wait_save_after", outs(), 32'b000);
`else
    check_eq("wait_save_after", outs(), 32'b001);
`endif
    timer = 1'b1; empty = 1'b1; step();
    check_eq("exec2_done", outs(), 32'b000);
    timer = 1'b0;

    // async reset in WAIT
    empty = 1'b0; execute = 1'b1; step();
    execute = 1'b0; step();
    check_eq("pre_reset_wait", outs(), 32'b001);
    #1 reset = 1'b1;
    #1;
    check_eq("async_reset", outs(), 32'b000);
    step();
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("post_reset_quiet", outs(), 32'b000);
    end

    // execute while empty ignored
    empty = 1'b1; execute = 1'b1; step();
    check_eq("empty_exec", outs(), 32'b000);
    execute = 1'b0; step();
    check_eq("empty_exec2", outs(), 32'b000);

    // simultaneous rises: save wins
    empty = 1'b0; full = 1'b0; save = 1'b1; execute = 1'b1; step();
    check_eq("simul_we", outs(), 32'b100);
    step();
    check_eq("simul_after", outs(), 32'b000);
    save = 1'b0; execute = 1'b0; step();
    check_eq("simul_no_read", outs(), 32'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
